// File: rtl/ct_ifu_tage_table_bank.sv
// TAGE predictor table bank: single-port storage behind a gated clock, an
// init sweep that zeroes every entry after reset, and a small FIFO of masked
// updates that is forwarded to same-index reads and drained when the port is
// free (or forcibly, once reads have starved it for STARVE_MAX cycles).
module ct_ifu_tage_table_bank #(
  parameter int INDEX_WIDTH = 10,
  parameter int DATA_WIDTH  = 64,
  parameter int BUF_DEPTH   = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  input  logic                   cp0_yy_clk_en,
  input  logic                   cp0_ifu_icg_en,
  input  logic                   pad_yy_icg_scan_en,
  input  logic                   rd_vld,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic                   rd_ready,
  output logic                   rd_data_vld,
  output logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   upd_vld,
  input  logic [INDEX_WIDTH-1:0] upd_index,
  input  logic [DATA_WIDTH-1:0]  upd_data,
  input  logic [DATA_WIDTH-1:0]  upd_mask,
  output logic                   upd_ready,
  output logic                   init_done
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [INDEX_WIDTH:0] INIT_LAST = (INDEX_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] index;
    logic [DATA_WIDTH-1:0]  data;
    logic [DATA_WIDTH-1:0]  mask;
  } upd_entry_t;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH:0]   init_ptr_q;
  upd_entry_t             buf_q [BUF_DEPTH];
  logic [CNT_W-1:0]       buf_cnt_q;
  logic [CNT_W-1:0]       wr_slot;
  logic [STV_W-1:0]       starve_q;
  logic                   rd_data_vld_q;
  logic [DATA_WIDTH-1:0]  rd_hold_q;
  logic [DATA_WIDTH-1:0]  byp_data, byp_mask;
  logic [DATA_WIDTH-1:0]  byp_data_q, byp_mask_q;
  logic [DATA_WIDTH-1:0]  rd_merged;

  logic                   buf_empty, buf_full, starve_hit;
  logic                   rd_acc, upd_acc, drain, init_wr;

  logic                   mem_clk, mem_clk_en;
  logic                   mem_we, mem_re;
  logic [INDEX_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]  mem_wdata, mem_wmask;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_rdata;

  assign buf_empty  = (buf_cnt_q == '0);
  assign buf_full   = (buf_cnt_q == CNT_W'(BUF_DEPTH));
  assign starve_hit = !buf_empty && (starve_q == STV_W'(STARVE_MAX));
  assign init_wr    = (state_q == ST_INIT);
  assign rd_acc     = rd_vld & rd_ready;
  assign upd_acc    = upd_vld & upd_ready;
  // A read always wins the port unless the starve override has already dropped rd_ready.
  assign drain      = (state_q == ST_RUN) & !buf_empty & !rd_acc;
  assign wr_slot    = drain ? buf_cnt_q - CNT_W'(1) : buf_cnt_q;

  // FSM state register.
  always_ff @(posedge forever_cpuclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!cpurst_b) state_q <= ST_INIT;
    else           state_q <= state_d;
  end

  // FSM next state: leave INIT once the last entry has been written.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    state_d = state_q;
    if (state_q == ST_INIT && init_ptr_q == INIT_LAST) state_d = ST_RUN;
  end

  // FSM outputs: handshakes are only offered once the table is clean.
  always_comb begin
    rd_ready  = 1'b0;
    upd_ready = 1'b0;
    init_done = 1'b0;
    if (state_q == ST_RUN) begin
      init_done = 1'b1;
      rd_ready  = !starve_hit;
      upd_ready = !buf_full;
    end
  end

  // Init sweep pointer; the extra MSB keeps the terminal compare unambiguous.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b)    init_ptr_q <= '0;
    else if (init_wr) init_ptr_q <= init_ptr_q + (INDEX_WIDTH + 1)'(1);
  end

  // Single-port arbitration: init write, else drain write, else read. Nothing touches the array in a reset cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = rd_index;
    mem_wdata = '0;
    mem_wmask = '0;
    if (cpurst_b) begin
      if (init_wr) begin
        mem_we    = 1'b1;
        mem_addr  = init_ptr_q[INDEX_WIDTH-1:0];
        mem_wmask = '1;
      end else if (drain) begin
        mem_we    = 1'b1;
        mem_addr  = buf_q[0].index;
        mem_wdata = buf_q[0].data;
        mem_wmask = buf_q[0].mask;
      end else if (rd_acc) begin
        mem_re = 1'b1;
      end
    end
  end

  assign mem_clk_en = init_wr | mem_we | mem_re;

  gated_clk_cell x_mem_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_ifu_icg_en),
    .local_en           (mem_clk_en),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (mem_clk)
  );

  // Storage array with per-bit write enable and a registered read port.
  always_ff @(posedge mem_clk) begin
    // NOTE: the array itself is never reset; the init sweep clears it after every reset.
    if (mem_we)      mem[mem_addr] <= (mem[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    else if (mem_re) mem_rdata     <= mem[mem_addr];
  end

  // Update FIFO: entry 0 is the oldest; a drain shifts down, an accept fills the first free slot after the shift.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      buf_cnt_q <= '0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (upd_acc && CNT_W'(i) == wr_slot) buf_q[i] <= '{index: upd_index, data: upd_data, mask: upd_mask};
        else if (drain)                      buf_q[i] <= buf_q[(i + 1) % BUF_DEPTH];
      end
      buf_cnt_q <= buf_cnt_q + CNT_W'(upd_acc) - CNT_W'(drain);
    end
  end

  // Starve counter: counts reads that blocked a pending drain, cleared by any drain.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b)                                   starve_q <= '0;
    else if (drain)                                  starve_q <= '0;
    else if (!buf_empty && rd_acc && !starve_hit)    starve_q <= starve_q + STV_W'(1);
  end

  // Bypass: merge buffered entries oldest to youngest so the youngest set mask bit wins.
  always_comb begin
    byp_data = '0;
    byp_mask = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (CNT_W'(i) < buf_cnt_q && buf_q[i].index == rd_index) begin
        byp_data = (byp_data & ~buf_q[i].mask) | (buf_q[i].data & buf_q[i].mask);
        byp_mask = byp_mask | buf_q[i].mask;
      end
    end
  end

  // Capture the bypass snapshot alongside the array read; only consumed while rd_data_vld is high.
  always_ff @(posedge forever_cpuclk) begin
    if (rd_acc) begin
      byp_data_q <= byp_data;
      byp_mask_q <= byp_mask;
    end
  end

  assign rd_merged = (mem_rdata & ~byp_mask_q) | (byp_data_q & byp_mask_q);

  // Read response: valid one cycle after acceptance, data held between reads.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      rd_data_vld_q <= 1'b0;
      rd_hold_q     <= '0;
    end else begin
      rd_data_vld_q <= rd_acc;
      if (rd_data_vld_q) rd_hold_q <= rd_merged;
    end
  end

  assign rd_data_vld = rd_data_vld_q;
  assign rd_data     = rd_data_vld_q ? rd_merged : rd_hold_q;

endmodule

// Latch-based clock gate: the enable is captured while clk_in is low so the
// gated clock cannot glitch; scan enable forces the clock on.
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic clk_en_bf_latch;
  logic clk_en;

  assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

  // Transparent-low enable latch.
  always_latch begin
    if (!clk_in) clk_en = clk_en_bf_latch | pad_yy_icg_scan_en;
  end

  assign clk_out = clk_in & clk_en;

endmodule

// File: tb/tb_ct_ifu_tage_table_bank.sv
// Self-checking bench for ct_ifu_tage_table_bank. A queue-based reference
// model of the table (flat array + FIFO of pending masked updates) predicts
// handshakes and read data; directed scenarios plus a random run compare
// the DUT against it or against hand-derived constants.
module tb_ct_ifu_tage_table_bank;

  localparam int IW    = 10;
  localparam int DW    = 64;
  localparam int BD    = 2;
  localparam int SM    = 4;
  localparam int DEPTH = 1 << IW;

  logic          forever_cpuclk = 1'b0;
  logic          cpurst_b;
  logic          cp0_yy_clk_en;
  logic          cp0_ifu_icg_en;
  logic          pad_yy_icg_scan_en;
  logic          rd_vld;
  logic [IW-1:0] rd_index;
  logic          rd_ready;
  logic          rd_data_vld;
  logic [DW-1:0] rd_data;
  logic          upd_vld;
  logic [IW-1:0] upd_index;
  logic [DW-1:0] upd_data;
  logic [DW-1:0] upd_mask;
  logic          upd_ready;
  logic          init_done;

  always #5 forever_cpuclk = ~forever_cpuclk;

  ct_ifu_tage_table_bank #(
    .INDEX_WIDTH (IW),
    .DATA_WIDTH  (DW),
    .BUF_DEPTH   (BD),
    .STARVE_MAX  (SM)
  ) dut (
    .forever_cpuclk     (forever_cpuclk),
    .cpurst_b           (cpurst_b),
    .cp0_yy_clk_en      (cp0_yy_clk_en),
    .cp0_ifu_icg_en     (cp0_ifu_icg_en),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .rd_vld             (rd_vld),
    .rd_index           (rd_index),
    .rd_ready           (rd_ready),
    .rd_data_vld        (rd_data_vld),
    .rd_data            (rd_data),
    .upd_vld            (upd_vld),
    .upd_index          (upd_index),
    .upd_data           (upd_data),
    .upd_mask           (upd_mask),
    .upd_ready          (upd_ready),
    .init_done          (init_done)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
  } upd_t;

  // Reference model state.
  upd_t          ref_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            ref_starve;
  int            ref_init_left;
  logic          ref_vld;
  logic [DW-1:0] ref_data;

  // Per-cycle expectations and DUT samples.
  logic          exp_rd_ready, exp_upd_ready, exp_init_done, exp_vld;
  logic [DW-1:0] exp_data;
  logic          act_rd_ready, act_upd_ready, act_init_done, act_vld;
  logic [DW-1:0] act_data;

  int n_checks = 0;
  int n_pass   = 0;

  // One clock cycle: drive inputs, predict, sample at negedge, advance the model.
  task automatic drive_cycle(input logic rst, input logic rv, input logic [IW-1:0] ri,
                             input logic uv, input logic [IW-1:0] ui,
                             input logic [DW-1:0] ud, input logic [DW-1:0] um);
    logic          rd_acc, upd_acc;
    logic [DW-1:0] v;
    upd_t          e;
    cpurst_b  = rst;
    rd_vld    = rv;
    rd_index  = ri;
    upd_vld   = uv;
    upd_index = ui;
    upd_data  = ud;
    upd_mask  = um;
    if (ref_init_left > 0) begin
      exp_rd_ready  = 1'b0;
      exp_upd_ready = 1'b0;
      exp_init_done = 1'b0;
    end else begin
      exp_rd_ready  = !(ref_q.size() > 0 && ref_starve == SM);
      exp_upd_ready = ref_q.size() < BD;
      exp_init_done = 1'b1;
    end
    exp_vld  = ref_vld;
    exp_data = ref_data;
    @(negedge forever_cpuclk);
    act_rd_ready  = rd_ready;
    act_upd_ready = upd_ready;
    act_init_done = init_done;
    act_vld       = rd_data_vld;
    act_data      = rd_data;
    if (!rst) begin
      ref_q.delete();
      ref_starve    = 0;
      ref_init_left = DEPTH;
      ref_vld       = 1'b0;
      ref_data      = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else if (ref_init_left > 0) begin
      ref_init_left--;
      ref_vld = 1'b0;
    end else begin
      rd_acc  = rv && exp_rd_ready;
      upd_acc = uv && exp_upd_ready;
      if (rd_acc) begin
        v = ref_mem[ri];
        for (int k = 0; k < ref_q.size(); k++)
          if (ref_q[k].idx == ri) v = (v & ~ref_q[k].mask) | (ref_q[k].data & ref_q[k].mask);
        ref_vld  = 1'b1;
        ref_data = v;
      end else begin
        ref_vld = 1'b0;
      end
      if (ref_q.size() > 0 && !rd_acc) begin
        e = ref_q.pop_front();
        ref_mem[e.idx] = (ref_mem[e.idx] & ~e.mask) | (e.data & e.mask);
        ref_starve = 0;
      end else if (ref_q.size() > 0) begin
        ref_starve = (ref_starve < SM) ? ref_starve + 1 : SM;
      end
      if (upd_acc) begin
        e.idx  = ui;
        e.data = ud;
        e.mask = um;
        ref_q.push_back(e);
      end
    end
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, '1, 1'b1, '0, '0, '0);
    n_checks++; if (act_rd_ready !== 1'b0) $display("FAIL reset_rd_ready: got %b want 0", act_rd_ready); else n_pass++;
    n_checks++; if (act_upd_ready !== 1'b0) $display("FAIL reset_upd_ready: got %b want 0", act_upd_ready); else n_pass++;
    n_checks++; if (act_vld !== 1'b0) $display("FAIL reset_rd_data_vld: got %b want 0", act_vld); else n_pass++;
    n_checks++; if (act_data !== '0) $display("FAIL reset_rd_data: got %h want 0", act_data); else n_pass++;
    n_checks++; if (act_init_done !== 1'b0) $display("FAIL reset_init_done: got %b want 0", act_init_done); else n_pass++;
  endtask

  task automatic test_init();
    int first_done = -1;
    int bad_ready  = 0;
    for (int k = 0; k <= DEPTH + 8; k++) begin
      drive_cycle(1'b1, 1'b1, 10'h3FF, 1'b0, '0, '0, '0);
      if (act_init_done === 1'b1) begin
        first_done = k;
        break;
      end
      if (act_rd_ready !== 1'b0 || act_upd_ready !== 1'b0) bad_ready++;
    end
    n_checks++; if (first_done != DEPTH) $display("FAIL init_done_cycle: got %0d want %0d", first_done, DEPTH); else n_pass++;
    n_checks++; if (bad_ready != 0) $display("FAIL init_ready_low: got %0d ready cycles want 0", bad_ready); else n_pass++;
    n_checks++; if (act_rd_ready !== 1'b1) $display("FAIL init_first_rd_ready: got %b want 1", act_rd_ready); else n_pass++;
    idle(1);
    n_checks++; if (act_vld !== 1'b1) $display("FAIL init_read_vld: got %b want 1", act_vld); else n_pass++;
    n_checks++; if (act_data !== 64'h0) $display("FAIL init_read_3ff: got %h want 0", act_data); else n_pass++;
  endtask

  task automatic test_full_mask();
    idle(2);
    drive_cycle(1'b1, 1'b0, '0, 1'b1, 10'd5, 64'hFFFF_0000_FFFF_0000, '1);
    n_checks++; if (act_upd_ready !== 1'b1) $display("FAIL full_upd_ready: got %b want 1", act_upd_ready); else n_pass++;
    idle(2);
    drive_cycle(1'b1, 1'b1, 10'd5, 1'b0, '0, '0, '0);
    n_checks++; if (act_rd_ready !== 1'b1) $display("FAIL full_rd_ready: got %b want 1", act_rd_ready); else n_pass++;
    idle(1);
    n_checks++; if (act_vld !== 1'b1) $display("FAIL full_rd_vld: got %b want 1", act_vld); else n_pass++;
    n_checks++; if (act_data !== 64'hFFFF_0000_FFFF_0000) $display("FAIL full_rd_data: got %h want ffff0000ffff0000", act_data); else n_pass++;
  endtask

  task automatic test_partial_mask();
    drive_cycle(1'b1, 1'b0, '0, 1'b1, 10'd7, '1, 64'h0000_0000_0000_00FF);
    drive_cycle(1'b1, 1'b1, 10'd7, 1'b0, '0, '0, '0);
    idle(1);
    n_checks++; if (act_data !== 64'hFF || act_vld !== 1'b1) $display("FAIL partial_bypass: got vld=%b %h want 1 ff", act_vld, act_data); else n_pass++;
    idle(2);
    drive_cycle(1'b1, 1'b1, 10'd7, 1'b0, '0, '0, '0);
    idle(1);
    n_checks++; if (act_data !== 64'hFF || act_vld !== 1'b1) $display("FAIL partial_drained: got vld=%b %h want 1 ff", act_vld, act_data); else n_pass++;
  endtask

  task automatic test_buffer_full();
    idle(2);
    drive_cycle(1'b1, 1'b1, 10'd100, 1'b1, 10'd9, {$urandom(), $urandom_range(0, 16777215), 8'hAA}, 64'hFF);
    drive_cycle(1'b1, 1'b1, 10'd100, 1'b1, 10'd9, {$urandom(), $urandom_range(0, 268435455), 4'h5}, 64'h0F);
    n_checks++; if (act_upd_ready !== 1'b1) $display("FAIL bfull_second_ready: got %b want 1", act_upd_ready); else n_pass++;
    drive_cycle(1'b1, 1'b1, 10'd9, 1'b1, 10'd9, {$urandom(), $urandom()}, '1);
    n_checks++; if (act_upd_ready !== 1'b0) $display("FAIL bfull_third_ready: got %b want 0", act_upd_ready); else n_pass++;
    n_checks++; if (act_rd_ready !== 1'b1) $display("FAIL bfull_rd_ready: got %b want 1", act_rd_ready); else n_pass++;
    idle(1);
    n_checks++; if (act_data !== 64'hA5 || act_vld !== 1'b1) $display("FAIL bfull_bypass: got vld=%b %h want 1 a5", act_vld, act_data); else n_pass++;
    idle(3);
    drive_cycle(1'b1, 1'b1, 10'd9, 1'b0, '0, '0, '0);
    idle(1);
    n_checks++; if (act_data !== 64'hA5) $display("FAIL bfull_drain_order: got %h want a5", act_data); else n_pass++;
  endtask

  task automatic test_starve();
    for (int r = 0; r < 2; r++) begin
      logic [IW-1:0] idx;
      logic [DW-1:0] val;
      int            blocked_at = -1;
      logic          resumed    = 1'b0;
      int            model_errs = 0;
      idx = IW'(40 + r);
      val = {$urandom(), $urandom()};
      idle(3);
      for (int c = 0; c < 10; c++) begin
        drive_cycle(1'b1, 1'b1, idx, c == 0, idx, val, '1);
        if (act_rd_ready === 1'b0 && blocked_at < 0) blocked_at = c;
        if (blocked_at >= 0 && c == blocked_at + 1) resumed = act_rd_ready;
        if (act_vld !== exp_vld || act_data !== exp_data) model_errs++;
      end
      idle(1);
      n_checks++; if (blocked_at != 5) $display("FAIL starve_block_cycle: got %0d want 5", blocked_at); else n_pass++;
      n_checks++; if (resumed !== 1'b1) $display("FAIL starve_resume: got %b want 1", resumed); else n_pass++;
      n_checks++; if (model_errs != 0) $display("FAIL starve_read_data: got %0d bad cycles want 0", model_errs); else n_pass++;
      n_checks++; if (act_data !== val) $display("FAIL starve_final_data: got %h want %h", act_data, val); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      logic          rv, uv;
      logic [IW-1:0] ri, ui;
      logic [DW-1:0] ud, um;
      rv = ($urandom_range(0, 99) < 70);
      uv = ($urandom_range(0, 99) < 50);
      ri = ($urandom_range(0, 9) == 0) ? IW'($urandom_range(0, DEPTH - 1)) : IW'($urandom_range(0, 7));
      ui = IW'($urandom_range(0, 7));
      ud = {$urandom(), $urandom()};
      um = ($urandom_range(0, 3) == 0) ? '1 : {$urandom(), $urandom()};
      drive_cycle(1'b1, rv, ri, uv, ui, ud, um);
      n_checks++; if (act_rd_ready !== exp_rd_ready) $display("FAIL rand_rd_ready @%0d: got %b want %b", n, act_rd_ready, exp_rd_ready); else n_pass++;
      n_checks++; if (act_upd_ready !== exp_upd_ready) $display("FAIL rand_upd_ready @%0d: got %b want %b", n, act_upd_ready, exp_upd_ready); else n_pass++;
      n_checks++; if (act_vld !== exp_vld) $display("FAIL rand_rd_data_vld @%0d: got %b want %b", n, act_vld, exp_vld); else n_pass++;
      n_checks++; if (act_data !== exp_data) $display("FAIL rand_rd_data @%0d: got %h want %h", n, act_data, exp_data); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int first_done = -1;
    idle(3);
    drive_cycle(1'b1, 1'b1, 10'd22, 1'b1, 10'd20, 64'h1234_5678_9ABC_DEF0, '1);
    drive_cycle(1'b1, 1'b1, 10'd22, 1'b1, 10'd21, 64'h0F0F_F0F0_5555_AAAA, '1);
    drive_cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    for (int k = 0; k <= DEPTH + 8; k++) begin
      drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
      if (k == 0) begin
        n_checks++; if (act_upd_ready !== 1'b0) $display("FAIL midrst_upd_ready: got %b want 0", act_upd_ready); else n_pass++;
        n_checks++; if (act_vld !== 1'b0) $display("FAIL midrst_rd_data_vld: got %b want 0", act_vld); else n_pass++;
        n_checks++; if (act_data !== '0) $display("FAIL midrst_rd_data: got %h want 0", act_data); else n_pass++;
      end
      if (act_init_done === 1'b1) begin
        first_done = k;
        break;
      end
    end
    n_checks++; if (first_done != DEPTH) $display("FAIL midrst_init_cycle: got %0d want %0d", first_done, DEPTH); else n_pass++;
    drive_cycle(1'b1, 1'b1, 10'd20, 1'b0, '0, '0, '0);
    drive_cycle(1'b1, 1'b1, 10'd21, 1'b0, '0, '0, '0);
    n_checks++; if (act_data !== '0 || act_vld !== 1'b1) $display("FAIL midrst_idx20: got vld=%b %h want 1 0", act_vld, act_data); else n_pass++;
    idle(1);
    n_checks++; if (act_data !== '0 || act_vld !== 1'b1) $display("FAIL midrst_idx21: got vld=%b %h want 1 0", act_vld, act_data); else n_pass++;
    idle(4);
    n_checks++; if (act_upd_ready !== 1'b1) $display("FAIL midrst_buffer_empty: got upd_ready=%b want 1", act_upd_ready); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cpurst_b           = 1'b0;
    cp0_yy_clk_en      = 1'b1;
    cp0_ifu_icg_en     = 1'b0;
    pad_yy_icg_scan_en = 1'b0;
    rd_vld             = 1'b0;
    rd_index           = '0;
    upd_vld            = 1'b0;
    upd_index          = '0;
    upd_data           = '0;
    upd_mask           = '0;
    ref_starve         = 0;
    ref_init_left      = DEPTH;
    ref_vld            = 1'b0;
    ref_data           = '0;
    test_reset();
    test_init();
    test_full_mask();
    test_partial_mask();
    test_buffer_full();
    test_starve();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
